// File: rtl/spi_cmd_tx.sv
// SPI command transmitter: queues {command, databyte1, databyte2} frames in a small
// FIFO and sends each one as a single cs-framed 24-bit mode-0 transfer, MSB first.
//   state | meaning
//   IDLE  | waiting for a queued frame; pops it and raises cs
//   SETUP | cs high, sck low for CLK_DIV cycles before the first rising edge
//   SHIFT | 24 sck periods; data advances on falling edges, then one low phase
//   HOLD  | cs high, sck low for CLK_DIV cycles; exit drops cs and pulses frame_done
//   GAP   | cs low for CS_GAP cycles before the next frame may start
module spi_cmd_tx #(
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CS_GAP     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_valid,
  output logic       frame_ready,
  input  logic [7:0] command,
  input  logic [7:0] databyte1,
  input  logic [7:0] databyte2,
  output logic       cs,
  output logic       sck,
  output logic       sdi,
  output logic       busy,
  output logic       frame_done
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] DIV_LOAD = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LOAD = TW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;
  state_t state, state_n;

  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;

  // bit 23 goes straight to sdi on pop, so only the remaining 23 bits are held here
  logic [22:0]   shreg, shreg_n;
  logic [4:0]    bit_cnt, bit_cnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic          tail, tail_n;
  logic          cs_n, sck_n, sdi_n, done_n;

  assign full        = (count == (AW+1)'(FIFO_DEPTH));
  assign empty       = (count == '0);
  assign frame_ready = ~full;
  assign push        = frame_valid & ~full;
  assign pop         = (state == IDLE) & ~empty;
  assign busy        = (state != IDLE) | ~empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {command, databyte1, databyte2};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      tmr        <= '0;
      tail       <= 1'b0;
      cs         <= 1'b0;
      sck        <= 1'b0;
      sdi        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_cnt_n;
      tmr        <= tmr_n;
      tail       <= tail_n;
      cs         <= cs_n;
      sck        <= sck_n;
      sdi        <= sdi_n;
      frame_done <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    tmr_n     = tmr;
    tail_n    = tail;
    cs_n      = cs;
    sck_n     = sck;
    sdi_n     = sdi;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        sdi_n = 1'b0;
        if (!empty) begin
          shreg_n   = mem[rd_ptr][22:0];
          sdi_n     = mem[rd_ptr][23];
          cs_n      = 1'b1;
          bit_cnt_n = '0;
          tail_n    = 1'b0;
          tmr_n     = DIV_LOAD;
          state_n   = SETUP;
        end
      end
      SETUP: begin
        if (tmr == '0) begin
          sck_n   = 1'b1;
          tmr_n   = DIV_LOAD;
          state_n = SHIFT;
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      SHIFT: begin
        if (tmr == '0) begin
          tmr_n = DIV_LOAD;
          if (sck) begin
            sck_n = 1'b0;
            // last bit stays on sdi so constant frames never toggle the line
            if (bit_cnt == 5'd23) begin
              tail_n = 1'b1;
            end else begin
              sdi_n     = shreg[22];
              shreg_n   = {shreg[21:0], 1'b0};
              bit_cnt_n = bit_cnt + 1'b1;
            end
          end else if (tail) begin
            state_n = HOLD;
          end else begin
            sck_n = 1'b1;
          end
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      HOLD: begin
        if (tmr == '0) begin
          cs_n    = 1'b0;
          sdi_n   = 1'b0;
          done_n  = 1'b1;
          tmr_n   = GAP_LOAD;
          state_n = GAP;
        end else begin
          tmr_n = tmr - 1'b1;
        end
      end
      GAP: begin
        if (tmr == '0) state_n = IDLE;
        else           tmr_n   = tmr - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_spi_cmd_tx.sv
// Bench for spi_cmd_tx: a default instance and a CLK_DIV=1/CS_GAP=1 instance, with a
// bit-level receiver model decoding cs/sck/sdi on the falling clk edge.
module tb_spi_cmd_tx;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  valid;
  logic [23:0] word_a, word_b;
  logic a_ready, a_cs, a_sck, a_sdi, a_busy, a_done;
  logic b_ready, b_cs, b_sck, b_sdi, b_busy, b_done;

  spi_cmd_tx dut_a (
    .clk(clk), .reset(reset), .frame_valid(valid[0]), .frame_ready(a_ready),
    .command(word_a[23:16]), .databyte1(word_a[15:8]), .databyte2(word_a[7:0]),
    .cs(a_cs), .sck(a_sck), .sdi(a_sdi), .busy(a_busy), .frame_done(a_done));

  spi_cmd_tx #(.CLK_DIV(1), .FIFO_DEPTH(4), .CS_GAP(1)) dut_b (
    .clk(clk), .reset(reset), .frame_valid(valid[1]), .frame_ready(b_ready),
    .command(word_b[23:16]), .databyte1(word_b[15:8]), .databyte2(word_b[7:0]),
    .cs(b_cs), .sck(b_sck), .sdi(b_sdi), .busy(b_busy), .frame_done(b_done));

  logic [1:0] cs_v, sck_v, sdi_v, done_v, ready_v, busy_v;
  assign cs_v    = {b_cs, a_cs};
  assign sck_v   = {b_sck, a_sck};
  assign sdi_v   = {b_sdi, a_sdi};
  assign done_v  = {b_done, a_done};
  assign ready_v = {b_ready, a_ready};
  assign busy_v  = {b_busy, a_busy};

  // receiver model state, written only by the monitor process
  logic [23:0] rx_q[2][$];
  int len_q[2][$];
  int bits_q[2][$];
  int flip_q[2][$];
  int done_cnt[2] = '{0, 0};
  int viol[2]     = '{0, 0};
  int misalign[2] = '{0, 0};
  int min_gap[2]  = '{1000, 1000};
  int hi_max[2]   = '{0, 0};
  int nbits[2]    = '{0, 0};
  int hi_len[2]   = '{0, 0};
  int lo_len[2]   = '{0, 0};
  int flips[2]    = '{0, 0};
  int hi_run[2]   = '{0, 0};
  logic [23:0] sh[2] = '{24'h0, 24'h0};
  logic [1:0] p_cs = '0, p_sck = '0, p_sdi = '0, seen = '0;

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        p_cs[g]   <= 1'b0;
        p_sck[g]  <= 1'b0;
        p_sdi[g]  <= 1'b0;
        seen[g]   <= 1'b0;
        hi_run[g] <= 0;
        if (done_v[g]) misalign[g] <= misalign[g] + 1;
      end else begin
        if (cs_v[g]) begin
          if (!p_cs[g]) begin
            if (seen[g] && lo_len[g] < min_gap[g]) min_gap[g] <= lo_len[g];
            hi_len[g] <= 1;
            nbits[g]  <= 0;
            sh[g]     <= '0;
            flips[g]  <= 0;
          end else begin
            hi_len[g] <= hi_len[g] + 1;
            if (sdi_v[g] != p_sdi[g]) flips[g] <= flips[g] + 1;
            if (sck_v[g] && !p_sck[g]) begin
              sh[g]    <= {sh[g][22:0], sdi_v[g]};
              nbits[g] <= nbits[g] + 1;
            end
          end
          if (sck_v[g] && sdi_v[g] != p_sdi[g]) viol[g] <= viol[g] + 1;
        end else begin
          if (p_cs[g]) begin
            rx_q[g].push_back(sh[g]);
            len_q[g].push_back(hi_len[g]);
            bits_q[g].push_back(nbits[g]);
            flip_q[g].push_back(flips[g]);
            seen[g]   <= 1'b1;
            lo_len[g] <= 1;
          end else begin
            lo_len[g] <= lo_len[g] + 1;
          end
          if (sck_v[g]) viol[g] <= viol[g] + 1;
        end
        if (sck_v[g]) begin
          hi_run[g] <= hi_run[g] + 1;
          if (hi_run[g] + 1 > hi_max[g]) hi_max[g] <= hi_run[g] + 1;
        end else begin
          hi_run[g] <= 0;
        end
        if (done_v[g]) begin
          done_cnt[g] <= done_cnt[g] + 1;
          if (!(p_cs[g] && !cs_v[g])) misalign[g] <= misalign[g] + 1;
        end
        p_cs[g]  <= cs_v[g];
        p_sck[g] <= sck_v[g];
        p_sdi[g] <= sdi_v[g];
      end
    end
  end

  int total = 0;
  int bad   = 0;
  int rdi[2]      = '{0, 0};
  int exp_done[2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int g, input logic [23:0] w);
    int n = 0;
    @(negedge clk);
    if (g == 0) word_a = w;
    else        word_b = w;
    valid[g] = 1'b1;
    while (!ready_v[g] && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check("push_timeout", 32'(ready_v[g]), 32'd1);
    @(posedge clk);
    #1;
    valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_v[g] && n < 3000);
    if (busy_v[g]) check("idle_timeout", 32'(busy_v[g]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input int g, input logic [23:0] exp, input int len, input int exp_flips);
    check("frame_present", 32'(rx_q[g].size() > rdi[g]), 32'd1);
    if (rx_q[g].size() > rdi[g]) begin
      check("frame_word", 32'(rx_q[g][rdi[g]]), 32'(exp));
      check("cs_high_len", 32'(len_q[g][rdi[g]]), 32'(len));
      check("sck_rises", 32'(bits_q[g][rdi[g]]), 32'd24);
      if (exp_flips >= 0) check("sdi_flips", 32'(flip_q[g][rdi[g]]), 32'(exp_flips));
      rdi[g]++;
    end
  endtask

  typedef struct packed {
    logic [7:0]  cmd;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[3];
  logic [23:0] burst_exp[8];

  initial begin
    #900000;
    $display("FAIL global_watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k, n, first_full_k, rises, base_rx, base_done;
    logic rdy, cs_prev, refill_seen, ps;

    vecs[0] = '{8'hA5, 8'h3C, 8'h0F, 24'hA53C0F};
    vecs[1] = '{8'h80, 8'h01, 8'h7E, 24'h80017E};
    vecs[2] = '{8'h01, 8'h55, 8'hAA, 24'h0155AA};
    burst_exp = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C,
                  24'h0D0E0F, 24'h101112, 24'h131415, 24'h161718};

    reset = 1'b1;
    valid = 2'b00;
    word_a = '0;
    word_b = '0;
    @(negedge clk);
    check("rst_cs", 32'(a_cs), 32'd0);
    check("rst_sck", 32'(a_sck), 32'd0);
    check("rst_sdi", 32'(a_sdi), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_ready", 32'(a_ready), 32'd1);
    check("rst_ready_b", 32'(b_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // single frames from the vector table
    for (int i = 0; i < 3; i++) begin
      push(0, {vecs[i].cmd, vecs[i].d1, vecs[i].d2});
      @(negedge clk);
      check("cs_low_in_pop_cycle", 32'(a_cs), 32'd0);
      check("busy_after_push", 32'(a_busy), 32'd1);
      @(negedge clk);
      check("cs_high_after_pop", 32'(a_cs), 32'd1);
      check("sdi_first_bit", 32'(a_sdi), 32'(vecs[i].exp[23]));
      wait_idle(0);
      exp_done[0]++;
      expect_frame(0, vecs[i].exp, 200, -1);
      check("done_count", 32'(done_cnt[0]), 32'(exp_done[0]));
    end
    check("sck_high_len_a", 32'(hi_max[0]), 32'd4);

    // all-zero and all-one frames back to back
    push(0, 24'h000000);
    push(0, 24'hFFFFFF);
    wait_idle(0);
    exp_done[0] += 2;
    expect_frame(0, 24'h000000, 200, 0);
    expect_frame(0, 24'hFFFFFF, 200, 0);
    check("done_count_pair", 32'(done_cnt[0]), 32'(exp_done[0]));
    check("gap_pair", 32'(min_gap[0]), 32'd9);

    // continuous burst; covers FIFO full and the push-blocked-during-pop boundary
    k = 0; n = 0; first_full_k = -1; refill_seen = 1'b0; cs_prev = a_cs;
    while (k < 8 && n < 5000) begin
      @(negedge clk);
      n++;
      valid[0] = 1'b1;
      word_a = burst_exp[k];
      rdy = a_ready;
      if (!rdy && first_full_k < 0) first_full_k = k;
      if (a_cs && !cs_prev && first_full_k >= 0 && !refill_seen) begin
        refill_seen = 1'b1;
        check("ready_after_full_pop", 32'(rdy), 32'd1);
        check("accepted_before_refill", 32'(k), 32'd5);
      end
      cs_prev = a_cs;
      @(posedge clk);
      if (rdy) k++;
    end
    @(negedge clk);
    valid[0] = 1'b0;
    check("first_full_at", 32'(first_full_k), 32'd5);
    check("refill_observed", 32'(refill_seen), 32'd1);
    check("burst_accepted", 32'(k), 32'd8);
    wait_idle(0);
    exp_done[0] += 8;
    for (int i = 0; i < 8; i++) expect_frame(0, burst_exp[i], 200, -1);
    check("burst_extra_frames", 32'(rx_q[0].size()), 32'(rdi[0]));
    check("done_count_burst", 32'(done_cnt[0]), 32'(exp_done[0]));
    check("gap_burst", 32'(min_gap[0]), 32'd9);

    // reset in the middle of a frame
    push(0, 24'h123456);
    n = 0; rises = 0; ps = a_sck;
    while (rises < 10 && n < 2000) begin
      @(negedge clk);
      n++;
      if (a_sck && !ps) rises++;
      ps = a_sck;
    end
    check("rises_before_reset", 32'(rises), 32'd10);
    #2;
    base_rx = rx_q[0].size();
    base_done = done_cnt[0];
    reset = 1'b1;
    #1;
    check("async_cs", 32'(a_cs), 32'd0);
    check("async_sck", 32'(a_sck), 32'd0);
    check("async_sdi", 32'(a_sdi), 32'd0);
    check("async_busy", 32'(a_busy), 32'd0);
    check("async_ready", 32'(a_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("no_frame_after_reset", 32'(rx_q[0].size()), 32'(base_rx));
    check("no_done_after_reset", 32'(done_cnt[0]), 32'(base_done));
    check("empty_after_reset", 32'(a_busy), 32'd0);
    push(0, 24'hC3A55A);
    wait_idle(0);
    exp_done[0]++;
    expect_frame(0, 24'hC3A55A, 200, -1);
    check("done_after_recovery", 32'(done_cnt[0]), 32'(exp_done[0]));

    // fastest corner: CLK_DIV=1, CS_GAP=1
    push(1, 24'hFF00FF);
    wait_idle(1);
    expect_frame(1, 24'hFF00FF, 50, -1);
    check("done_count_b", 32'(done_cnt[1]), 32'd1);
    check("sck_high_len_b", 32'(hi_max[1]), 32'd1);

    check("sdi_change_at_sck_high_a", 32'(viol[0]), 32'd0);
    check("sdi_change_at_sck_high_b", 32'(viol[1]), 32'd0);
    check("done_alignment_a", 32'(misalign[0]), 32'd0);
    check("done_alignment_b", 32'(misalign[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_cmd_tx.md
Name: spi_cmd_tx

Overview:
- SPI command transmitter, the sending end of the three-byte command link that carries command, databyte1 and databyte2 into the graphics card's SPI receiver.
- Used as the host-side frame source in the FPGA test harness and loopback builds, and as the master when one FPGA drives a second graphics card.
- Accepts frames through a valid/ready interface, queues them in a small FIFO, and serializes each as one 24-bit cs-framed SPI transfer.

Parameters:
- CLK_DIV, 4: sck half-period in clk cycles; must be at least 1.
- FIFO_DEPTH, 4: number of queued frames; must be a power of two, at least 2.
- CS_GAP, 8: minimum clk cycles cs stays low between frames; must be at least 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- frame_valid  in  1  upstream offers a frame.
- frame_ready  out  1  FIFO can accept a frame.
- command  in  8  command byte of the offered frame.
- databyte1  in  8  first data byte.
- databyte2  in  8  second data byte.
- cs  out  1  chip select, active-high, asserted for the whole frame.
- sck  out  1  SPI clock, idles low (mode 0).
- sdi  out  1  serial data to receiver, MSB first.
- busy  out  1  high when a frame is in flight or the FIFO is non-empty.
- frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (async): cs=0, sck=0, sdi=0, frame_done=0, busy=0, frame_ready=1. FIFO emptied; FSM returns to IDLE. A frame in progress is abandoned with no frame_done pulse.
- Push: a frame is accepted when frame_valid & frame_ready on a rising clk edge. The word is {command, databyte1, databyte2}, with command in bits 23:16.
- frame_ready = ~full. A push is never accepted while full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: both occur and the count is unchanged.
- FIFO preserves order. Count wraps correctly at FIFO_DEPTH.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - If the FIFO is non-empty: pop into the 24-bit shift register, then cs=1, sdi=bit23, go to SETUP.
  - Otherwise sdi=0.
- SETUP: hold CLK_DIV cycles with sck=0, then go to SHIFT.
- SHIFT:
  - sck toggles every CLK_DIV cycles, giving 24 rising edges.
  - The receiver samples sdi on the rising edge.
  - On each falling edge, the shift register shifts left and sdi presents the next bit.
  - After the 24th falling edge (sck low), go to HOLD.
- HOLD: CLK_DIV cycles with cs=1 and sck=0. Then cs=0, frame_done pulses for 1 cycle, sdi=0, go to GAP.
- GAP: CS_GAP cycles with cs low, then go to IDLE. Back-to-back frames therefore have at least CS_GAP+1 cs-low cycles between them (includes the IDLE cycle).
- Frame timing: cs high for exactly 50*CLK_DIV cycles; with default CLK_DIV=4 that is 200 cycles. sck high time = sck low time = CLK_DIV cycles.
- sdi changes only while sck is low or at the cs edge, never at a rising sck edge.
- busy = (state != IDLE) | ~empty. It deasserts in the IDLE cycle following GAP when the FIFO is empty.
- Bit counter is 5 bits, counting 0..23; it must not wrap inside a frame.
- All outputs are registered, so there are no combinational glitches on cs, sck or sdi.

Test Plan:
1. Single frame, defaults: push 0xA5, 0x3C, 0x0F. Required: cs rises one cycle after pop, stays high 200 cycles. The bits sampled on the 24 sck rising edges equal 0xA53C0F, MSB first. frame_done pulses once as cs falls. busy drops after GAP.
2. Burst: assert frame_valid continuously with incrementing payloads 0x010203, 0x040506, and so on. Required:
   - frame_ready goes low once 4 frames are queued.
   - Every accepted frame is received in order with no loss or duplication.
   - cs stays low at least 9 cycles between frames.
3. Full-boundary push/pop: with the FIFO full and frame_valid high while a pop occurs, the push is not accepted that cycle. frame_ready rises the next cycle and the frame is accepted then.
4. Reset mid-frame: assert reset after the 10th sck rising edge. Required:
   - cs, sck and sdi go to 0 immediately (asynchronously).
   - No frame_done pulse; the FIFO is empty.
   - A new push after release transmits correctly from bit 23.
5. Parameter corner, CLK_DIV=1 and CS_GAP=1: frame 0xFF00FF gives cs high for 50 cycles, a 1-cycle sck high/low, and a correctly received frame.
6. All-zero and all-one frames (0x000000, 0xFFFFFF) back-to-back: sdi is held constant through each frame, both are received exactly, and there are two frame_done pulses.
